clk_div_ctrl: RTL and testbench
===============================

CLK_DIV_CTRL -- requirements
Module: clk_div_ctrl

Interface
REQ-001 Parameter: max_div_bits, 4, width of the divide-ratio field.
REQ-002 Parameter: gap_cyc, 2, number of ref-clock cycles the divider enable is held low before a new ratio is loaded.
REQ-003 Port: i_ref_clk  in  1  single clock for all logic.
REQ-004 Port: i_rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: i_req0_valid  in  1  requester 0 asks for a ratio change; held high until granted.
REQ-006 Port: i_req0_ratio  in  max_div_bits  ratio requested by requester 0.
REQ-007 Port: o_req0_ready  out  1  one-cycle grant/capture strobe to requester 0.
REQ-008 Ports: i_req1_valid, i_req1_ratio, o_req1_ready, with the same directions, widths and meanings for requester 1.
REQ-009 Port: i_div_clk  in  1  divider output, fed back for boundary detection.
REQ-010 Port: o_clk_en  out  1  drives the divider clock enable.
REQ-011 Port: o_div_ratio  out  max_div_bits  drives the divider ratio.
REQ-012 Port: o_busy  out  1  high in every state except IDLE.
REQ-013 Port: o_done  out  1  one-cycle pulse when a change completes.
REQ-014 Port: o_done_id  out  1  requester served; valid while o_done is high.

Function
REQ-015 States: INIT, IDLE, QUIESCE, GATE, LOAD, SETTLE, DONE. All outputs are registered.
REQ-016 INIT lasts one cycle, sets o_clk_en=1, then goes to IDLE.
REQ-017 Arbitration in IDLE:
- Round-robin between the two requesters.
- When both are valid, the requester not served last wins; after reset, requester 0 wins.
- Grant cycle: the matching o_reqN_ready=1 and the ratio is captured.
REQ-018 A captured ratio of 0 is normalised to 1; both 0 and 1 mean bypass.
REQ-019 If the normalised ratio equals the current o_div_ratio, go IDLE->DONE directly, with no gating.
REQ-020 Otherwise go to QUIESCE.
REQ-021 i_div_clk is sampled through one register.
REQ-022 QUIESCE exit conditions:
- Exit to GATE on the first cycle the sampled i_div_clk is 0.
- Timeout: exit to GATE after 2^(max_div_bits+1) cycles regardless of i_div_clk.
REQ-023 GATE: o_clk_en=0 for exactly gap_cyc cycles, then go to LOAD.
REQ-024 LOAD lasts one cycle:
- o_div_ratio takes the new ratio.
- o_clk_en stays 0.
- Next state is SETTLE.
REQ-025 SETTLE:
- o_clk_en=1 from the first SETTLE cycle.
- Stay for 2*ratio cycles (2 when bypass), then go to DONE.
REQ-026 DONE lasts one cycle: o_done=1 and o_done_id is set, then go to IDLE.
REQ-027 Requests are not sampled outside IDLE. At most one grant occurs per change.
REQ-028 The settle counter is max_div_bits+2 bits wide and does not wrap within one change.
REQ-029 i_div_clk must not alter state outside QUIESCE.

Reset
REQ-030 On i_rst_n low, all of the following take effect immediately and asynchronously:
- state = INIT
- o_clk_en = 0
- o_div_ratio = 1
- o_busy = 1
- o_done = 0, o_done_id = 0
- o_req0_ready = 0, o_req1_ready = 0
- round-robin pointer favours requester 0
- all counters = 0
REQ-031 A reset asserted mid-change abandons the change. No o_done pulse is issued for it.

Structure
REQ-032 A shared package holds the state enumeration and the settle/timeout width constants.
REQ-033 The round-robin arbiter is a sub-module named clk_div_rr_arb. It has 2 requests, a one-hot grant, and a registered last-grant pointer.

Verification
REQ-034 Reset release, no requests -> o_clk_en=0 in the first cycle, 1 from the second, o_div_ratio=1, o_busy=0 after INIT.
REQ-035 req0 ratio=4 with i_div_clk low -> ready 1 cycle, QUIESCE 1 cycle, o_clk_en=0 for 2 cycles, o_div_ratio=4 in LOAD, 8 SETTLE cycles, o_done=1 with o_done_id=0.
REQ-036 req0 and req1 valid in the same cycle after reset (ratios 3 and 6) -> req0 served first; req1 granted in the next IDLE; final o_div_ratio=6.
REQ-037 i_div_clk held at 1, request ratio=5 -> QUIESCE times out after 32 cycles, then the normal sequence follows.
REQ-038 Request ratio=0 while o_div_ratio=1 -> no gating, DONE two cycles after the grant, ratio unchanged.
REQ-039 Reset asserted during SETTLE -> outputs take reset values immediately, no o_done, INIT follows release.

Source files
------------

// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and width helpers for the divider ratio-change controller.
package clk_div_ctrl_pkg;

    localparam int unsigned DefDivBits = 4;
    localparam int unsigned DefGapCyc  = 2;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StQuiesce,
        StGate,
        StLoad,
        StSettle,
        StDone
    } state_e;

    // Settle needs 2*ratio counts without wrapping; timeout needs 2^(bits+1) counts.
    function automatic int unsigned settle_cnt_w(input int unsigned div_bits);
        return div_bits + 2;
    endfunction

    function automatic int unsigned tmo_cnt_w(input int unsigned div_bits);
        return div_bits + 1;
    endfunction

    localparam int unsigned SettleCntW = settle_cnt_w(DefDivBits);
    localparam int unsigned TmoCntW    = tmo_cnt_w(DefDivBits);

endpackage

// File: rtl/clk_div_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
module clk_div_rr_arb (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic last_q;
    logic last_d;
    logic [1:0] gnt;

    always_comb begin
        gnt = i_req;
        // On contention the requester not served last wins.
        if (i_req == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
        last_d = last_q;
        if (i_en && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign o_gnt = gnt;

endmodule

// File: rtl/clk_div_ctrl.sv
// Safe ratio-change sequencer for a clock divider: arbitrate, quiesce, gate, load, settle.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned max_div_bits = DefDivBits,
    parameter int unsigned gap_cyc      = DefGapCyc
) (
    input  logic                    i_ref_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req0_valid,
    input  logic [max_div_bits-1:0] i_req0_ratio,
    output logic                    o_req0_ready,
    input  logic                    i_req1_valid,
    input  logic [max_div_bits-1:0] i_req1_ratio,
    output logic                    o_req1_ready,
    input  logic                    i_div_clk,
    output logic                    o_clk_en,
    output logic [max_div_bits-1:0] o_div_ratio,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_done_id
);

    localparam int unsigned CntW = settle_cnt_w(max_div_bits);
    localparam int unsigned TmoW = tmo_cnt_w(max_div_bits);
    localparam logic [CntW-1:0] TmoLast = CntW'({TmoW{1'b1}});
    localparam logic [CntW-1:0] GapLast = CntW'(gap_cyc - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [max_div_bits-1:0] RatioOne = max_div_bits'(1);

    state_e                  state_q, state_d;
    logic                    clk_en_q, clk_en_d;
    logic [max_div_bits-1:0] div_ratio_q, div_ratio_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    done_id_q, done_id_d;
    logic [1:0]              ready_q, ready_d;
    logic [max_div_bits-1:0] new_ratio_q, new_ratio_d;
    logic                    id_q, id_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    div_sync_q, div_sync_d;

    logic [1:0]              arb_gnt;
    logic                    arb_en;
    logic [max_div_bits-1:0] sel_ratio;
    logic [max_div_bits-1:0] norm_ratio;
    logic [CntW-1:0]         settle_last;

    clk_div_rr_arb u_arb (
        .i_clk   (i_ref_clk),
        .i_rst_n (i_rst_n),
        .i_req   ({i_req1_valid, i_req0_valid}),
        .i_en    (arb_en),
        .o_gnt   (arb_gnt)
    );

    assign sel_ratio   = ready_q[1] ? i_req1_ratio : i_req0_ratio;
    assign norm_ratio  = (sel_ratio == '0) ? RatioOne : sel_ratio;
    assign settle_last = {1'b0, new_ratio_q, 1'b0} - CntOne;

    always_comb begin
        state_d     = state_q;
        clk_en_d    = clk_en_q;
        div_ratio_d = div_ratio_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        done_id_d   = done_id_q;
        ready_d     = 2'b00;
        new_ratio_d = new_ratio_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        div_sync_d  = i_div_clk;
        arb_en      = 1'b0;

        unique case (state_q)
            StInit: begin
                state_d  = StIdle;
                clk_en_d = 1'b1;
                busy_d   = 1'b0;
            end
            StIdle: begin
                // Ratio is captured in the cycle the ready strobe is visible.
                if (ready_q != 2'b00) begin
                    new_ratio_d = norm_ratio;
                    id_d        = ready_q[1];
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    if (norm_ratio == div_ratio_q) begin
                        state_d   = StDone;
                        done_d    = 1'b1;
                        done_id_d = ready_q[1];
                    end else begin
                        state_d = StQuiesce;
                    end
                end else if (i_req0_valid || i_req1_valid) begin
                    ready_d = arb_gnt;
                    arb_en  = 1'b1;
                end
            end
            StQuiesce: begin
                if (!div_sync_q || (cnt_q == TmoLast)) begin
                    state_d  = StGate;
                    clk_en_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StGate: begin
                if (cnt_q == GapLast) begin
                    state_d     = StLoad;
                    div_ratio_d = new_ratio_q;
                    cnt_d       = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StLoad: begin
                state_d  = StSettle;
                clk_en_d = 1'b1;
                cnt_d    = '0;
            end
            StSettle: begin
                if (cnt_q == settle_last) begin
                    state_d   = StDone;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StInit;
            clk_en_q    <= 1'b0;
            div_ratio_q <= RatioOne;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            done_id_q   <= 1'b0;
            ready_q     <= 2'b00;
            new_ratio_q <= RatioOne;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            div_sync_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            div_ratio_q <= div_ratio_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            done_id_q   <= done_id_d;
            ready_q     <= ready_d;
            new_ratio_q <= new_ratio_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            div_sync_q  <= div_sync_d;
        end
    end

    assign o_clk_en     = clk_en_q;
    assign o_div_ratio  = div_ratio_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_done_id    = done_id_q;
    assign o_req0_ready = ready_q[0];
    assign o_req1_ready = ready_q[1];

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: each ratio change is predicted as a timeline of phase lengths.
module tb_clk_div_ctrl;

    localparam int unsigned DivBits = 4;
    localparam int unsigned Gap     = 2;
    localparam int          Tmo     = 2 ** (DivBits + 1);

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       req0_valid = 1'b0;
    logic [3:0] req0_ratio = 4'd0;
    logic       req1_valid = 1'b0;
    logic [3:0] req1_ratio = 4'd0;
    logic       div_clk    = 1'b0;
    logic       ready0;
    logic       ready1;
    logic       clk_en;
    logic [3:0] div_ratio;
    logic       busy;
    logic       done;
    logic       done_id;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] cur;          // divider ratio the model believes is in force
    int         last_served;  // requester the model believes was served last

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .max_div_bits (DivBits),
        .gap_cyc      (Gap)
    ) dut (
        .i_ref_clk    (clk),
        .i_rst_n      (rst_n),
        .i_req0_valid (req0_valid),
        .i_req0_ratio (req0_ratio),
        .o_req0_ready (ready0),
        .i_req1_valid (req1_valid),
        .i_req1_ratio (req1_ratio),
        .o_req1_ready (ready1),
        .i_div_clk    (div_clk),
        .o_clk_en     (clk_en),
        .o_div_ratio  (div_ratio),
        .o_busy       (busy),
        .o_done       (done),
        .o_done_id    (done_id)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_en, input logic [3:0] e_ratio,
                            input logic e_busy, input logic e_done, input logic e_id,
                            input logic [1:0] e_rdy);
        check({tag, ".clk_en"}, 8'(clk_en), 8'(e_en));
        check({tag, ".ratio"}, 8'(div_ratio), 8'(e_ratio));
        check({tag, ".busy"}, 8'(busy), 8'(e_busy));
        check({tag, ".done"}, 8'(done), 8'(e_done));
        check({tag, ".ready"}, 8'({ready1, ready0}), 8'(e_rdy));
        if (e_done) check({tag, ".done_id"}, 8'(done_id), 8'(e_id));
    endtask

    task automatic step_chk(input string tag, input logic e_en, input logic [3:0] e_ratio,
                            input logic e_busy, input logic e_done, input logic e_id,
                            input logic [1:0] e_rdy);
        @(posedge clk);
        #1;
        chk_outs(tag, e_en, e_ratio, e_busy, e_done, e_id, e_rdy);
    endtask

    // Reset asynchronously mid-cycle, then release and expect one INIT cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;
        chk_outs("reset_async", 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        check("reset_done_id", 8'(done_id), 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_outs("init", 1'b0, 4'd1, 1'b1, 1'b0, 1'b0, 2'b00);
        step_chk("init_exit", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        cur = 4'd1;
        last_served = 1;
    endtask

    // Called in the IDLE cycle in which requester id is already valid.
    // j < 0: div_clk low before QUIESCE; else it drops in QUIESCE cycle j.
    // abort_after >= 0 returns early after that SETTLE cycle index.
    task automatic serve(input int id, input logic [3:0] r_in, input int j,
                         input int abort_after);
        logic [3:0] r;
        logic [1:0] rdy;
        logic       e_id;
        int         q;
        int         lim;
        r    = (r_in == 4'd0) ? 4'd1 : r_in;
        rdy  = (id == 0) ? 2'b01 : 2'b10;
        e_id = (id != 0);
        q    = (j + 2 > Tmo) ? Tmo : j + 2;
        lim  = 2 * int'(r);
        step_chk("grant", 1'b1, cur, 1'b0, 1'b0, 1'b0, rdy);
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
        div_clk = (j < 0) ? 1'b0 : 1'b1;
        if (r == cur) begin
            step_chk("done_nochg", 1'b1, cur, 1'b1, 1'b1, e_id, 2'b00);
        end else begin
            for (int k = 0; k < q; k++) begin
                step_chk("quiesce", 1'b1, cur, 1'b1, 1'b0, 1'b0, 2'b00);
                if (k == j) div_clk = 1'b0;
            end
            for (int k = 0; k < int'(Gap); k++) begin
                step_chk("gate", 1'b0, cur, 1'b1, 1'b0, 1'b0, 2'b00);
                div_clk = 1'($urandom);
            end
            step_chk("load", 1'b0, r, 1'b1, 1'b0, 1'b0, 2'b00);
            cur = r;
            for (int k = 0; k < lim; k++) begin
                step_chk("settle", 1'b1, r, 1'b1, 1'b0, 1'b0, 2'b00);
                div_clk = 1'($urandom);
                if (k == abort_after) return;
            end
            step_chk("done", 1'b1, r, 1'b1, 1'b1, e_id, 2'b00);
        end
        last_served = id;
        step_chk("idle", 1'b1, cur, 1'b0, 1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        int         j;
        int         j2;
        int         mode;
        int         w;
        logic [3:0] ra;
        logic [3:0] rb;

        #2;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            div_clk = 1'($urandom);
            step_chk("idle_quiet", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        end

        // Simultaneous requests after reset: requester 0 first, then 1.
        req0_ratio = 4'd3;
        req1_ratio = 4'd6;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        serve(0, 4'd3, -1, -1);
        serve(1, 4'd6, -1, -1);
        check("final_ratio_6", 8'(div_ratio), 8'd6);

        do_reset();
        // Ratio 0 while at 1: bypass either way, no gating.
        req0_ratio = 4'd0;
        req0_valid = 1'b1;
        serve(0, 4'd0, -1, -1);
        // Plain change to 4 with the divider output already low.
        req0_ratio = 4'd4;
        req0_valid = 1'b1;
        serve(0, 4'd4, -1, -1);
        // Divider output stuck high: QUIESCE must time out.
        req1_ratio = 4'd5;
        req1_valid = 1'b1;
        serve(1, 4'd5, 40, -1);

        for (int it = 0; it < 14; it++) begin
            mode = int'($urandom_range(0, 2));
            ra   = ($urandom_range(0, 3) == 0) ? cur : 4'($urandom);
            rb   = 4'($urandom);
            j    = int'($urandom_range(0, 36)) - 1;
            j2   = int'($urandom_range(0, 36)) - 1;
            if (mode == 0) begin
                w = int'($urandom_range(0, 1));
                if (w == 0) begin
                    req0_ratio = ra;
                    req0_valid = 1'b1;
                end else begin
                    req1_ratio = ra;
                    req1_valid = 1'b1;
                end
                serve(w, ra, j, -1);
            end else begin
                req0_ratio = ra;
                req1_ratio = rb;
                req0_valid = 1'b1;
                req1_valid = 1'b1;
                w = (last_served == 0) ? 1 : 0;
                serve(w, (w == 0) ? ra : rb, j, -1);
                serve(1 - w, (w == 0) ? rb : ra, j2, -1);
            end
        end

        // Reset during SETTLE abandons the change without a done pulse.
        ra = (cur == 4'd7) ? 4'd9 : 4'd7;
        req0_ratio = ra;
        req0_valid = 1'b1;
        serve(0, ra, -1, 3);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step_chk("post_abort_idle", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 2'b00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
